cache_mem_responder: RTL and testbench
======================================

# cache_mem_responder

Memory-side responder for the cache's valid-ready memory port. It accepts single-word read and write requests issued by the cache and serves them from an internal `prim_ram` backing store after a programmable access latency. It sits below the cache in simulation and FPGA builds, where it stands in for the main-memory controller.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must match the cache.
- `ADDR_WIDTH`, 16: word address width; must match the cache.
- `MEM_DEPTH`, 4096: backing-store depth in words, with 1 ≤ `MEM_DEPTH` ≤ 2^`ADDR_WIDTH`.
- `LATENCY`, 4: extra wait cycles before each access, with 0 ≤ `LATENCY` ≤ 255.
- `clk_i` input 1: the single clock; all logic is on its rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `mem_valid_i` input 1: a request is present.
- `mem_ready_o` output 1: one-cycle pulse that completes the request (accept and response in one).
- `mem_we_i` input 1: 1 means write, 0 means read.
- `mem_adr_i` input `ADDR_WIDTH`: word address.
- `mem_wdata_i` input `DATA_WIDTH`: write data.
- `mem_rdata_o` output `DATA_WIDTH`: read data, meaningful while `mem_ready_o` is high for a read.
- `err_o` output 1: one-cycle pulse, coincident with `mem_ready_o`, when the address is ≥ `MEM_DEPTH`.
- `rd_cnt_o` output 16: count of completed reads.
- `wr_cnt_o` output 16: count of completed writes.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - When `mem_valid_i` is 1, latch `mem_we_i`, `mem_adr_i` and `mem_wdata_i` into request registers.
  - Load `cnt_q` with `LATENCY` and go to WAIT.
  - Inputs are not sampled in any other state.
- **WAIT**
  - While `cnt_q` ≠ 0, decrement it.
  - When `cnt_q` = 0:
    - For an in-range request, pulse the `prim_ram` enable with `we` = latched `we`, `addr` = latched address and `wdata` = latched data.
    - For an out-of-range request, do not enable the RAM.
    - Go to RESP.
- **RESP**
  - Drive `mem_ready_o` = 1.
  - `mem_rdata_o` is the `prim_ram` `rdata_o` for an in-range read and `'0` for an out-of-range read.
  - `err_o` = 1 if the address is out of range.
  - Update the counters and go to IDLE.
- Outside RESP, `mem_rdata_o` holds `rdata_hold_q`, the last value driven in RESP; this register loads on the RESP edge.
- Writes respond in exactly the same cycle pattern as reads; `mem_rdata_o` during a write's RESP equals `rdata_hold_q`.
- Out-of-range writes are dropped without touching the RAM. Out-of-range reads return zero. Both still complete normally.
- Counters saturate at 16'hFFFF. An out-of-range access still counts as a completed read or write.
- The initiator holds its request stable until it sees `mem_ready_o`. A `mem_valid_i` that is still high in the IDLE cycle after RESP is treated as a new request.

## Timing
- Let cycle 0 be the IDLE cycle in which `mem_valid_i` = 1 is sampled.
- WAIT occupies cycles 1 through `LATENCY`+1. RESP, with `mem_ready_o` = 1, is cycle `LATENCY`+2.
- Minimum latency is 2 cycles (at `LATENCY` = 0).
- The earliest next acceptance is cycle `LATENCY`+3, so back-to-back throughput is one request per `LATENCY`+3 cycles.
- `mem_ready_o` and `err_o` are high for exactly one cycle per request and never high outside RESP.
- Reset values: state IDLE, `mem_ready_o` = 0, `err_o` = 0, `mem_rdata_o` = 0, `rdata_hold_q` = 0, `cnt_q` = 0, `rd_cnt_o` = 0, `wr_cnt_o` = 0.
- Reset asserted mid-request:
  - The request is abandoned with no response.
  - A write whose RAM enable already fired stays written.
  - RAM contents are not cleared by reset.
- When an address change and `mem_valid_i` arrive in the same edge as a return to IDLE, they are sampled in the following cycle, not that edge.

## Configuration
- `CACHE_MEM_RESPONDER_STATS_EN` defined: `rd_cnt_o` and `wr_cnt_o` count as described.
- `CACHE_MEM_RESPONDER_STATS_EN` undefined:
  - The counter registers are not built.
  - `rd_cnt_o` and `wr_cnt_o` are tied to 16'h0000.
  - Ports are unchanged; all other behaviour is identical.

## Test plan
- Write then read, `LATENCY` = 4:
  - Stimulus: write 0x0010 ← 0xDEADBEEF, then read 0x0010.
  - Response: each `mem_ready_o` arrives in cycle 6 after acceptance; the read returns 0xDEADBEEF with `err_o` = 0.
- `LATENCY` = 0 back-to-back:
  - Stimulus: hold `mem_valid_i` high and issue 3 reads to addresses 1, 2 and 3, each previously written with 0x11, 0x22 and 0x33.
  - Response: ready pulses come every 3 cycles with data 0x11, 0x22, 0x33.
- Out of range, `MEM_DEPTH` = 4096:
  - Stimulus: write 0x1000 ← 0xA5A5A5A5, then read 0x1000.
  - Response: both complete with `err_o` = 1 and the read returns 0. A read of 0x0000 shows RAM word 0 unchanged.
- Reset mid-WAIT:
  - Stimulus: assert `rst_ni` = 0 in cycle 2 of a read.
  - Response: no `mem_ready_o` is issued. All outputs are 0 during reset and after release. A fresh request then completes normally.
- Counters, with `CACHE_MEM_RESPONDER_STATS_EN` defined:
  - Stimulus: 5 reads and 3 writes.
  - Response: `rd_cnt_o` = 5 and `wr_cnt_o` = 3. Forcing `rd_cnt_o` to 16'hFFFF and issuing one more read leaves it at 16'hFFFF.
- Macro undefined:
  - Stimulus: the same traffic.
  - Response: the counters stay 0 and data and timing match the defined build.

Source files
------------

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache valid-ready port: serves single-word reads/writes
// from an internal prim_ram backing store after LATENCY wait cycles.
// Optional statistics counters: define CACHE_MEM_RESPONDER_STATS_EN.
module cache_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 4096,
  parameter int LATENCY    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_adr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  err_o,
  output logic [15:0]           rd_cnt_o,
  output logic [15:0]           wr_cnt_o
);

  localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q;
  logic                  req_we_q;
  logic [ADDR_WIDTH-1:0] req_adr_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [DATA_WIDTH-1:0] rdata_hold_q, rdata_d;
  logic                  in_range;
  logic                  ram_en;
  logic [RAM_AW-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  assign in_range = ({1'b0, req_adr_q} < DEPTH_LIM);
  assign ram_addr = req_adr_q[RAM_AW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rdata_hold_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && mem_valid_i) begin
        cnt_q <= 8'(LATENCY);
      end else if (state_q == WAIT && cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (state_q == RESP) begin
        rdata_hold_q <= rdata_d;
      end
    end
  end

  // Request capture: only the IDLE cycle samples the initiator.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && mem_valid_i) begin
      req_we_q    <= mem_we_i;
      req_adr_q   <= mem_adr_i;
      req_wdata_q <= mem_wdata_i;
    end
  end

  // prim_ram backing store: one-cycle synchronous access, contents survive reset.
  always_ff @(posedge clk_i) begin
    if (ram_en) begin
      if (req_we_q) begin
        mem_q[ram_addr] <= req_wdata_q;
      end else begin
        ram_rdata_q <= mem_q[ram_addr];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ram_en      = 1'b0;
    mem_ready_o = 1'b0;
    err_o       = 1'b0;
    rdata_d     = rdata_hold_q;
    case (state_q)
      IDLE: begin
        if (mem_valid_i) state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          ram_en  = in_range;
          state_d = RESP;
        end
      end
      RESP: begin
        mem_ready_o = 1'b1;
        err_o       = ~in_range;
        if (!req_we_q) rdata_d = in_range ? ram_rdata_q : '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_rdata_o = rdata_d;

`ifdef CACHE_MEM_RESPONDER_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == RESP) begin
      if (req_we_q) wr_cnt_q <= sat_inc(wr_cnt_q);
      else          rd_cnt_q <= sat_inc(rd_cnt_q);
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`else
  assign rd_cnt_o = 16'h0000;
  assign wr_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: one instance at LATENCY=4, one at LATENCY=0.
module tb_cache_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v   [2];
  logic        we  [2];
  logic [15:0] adr [2];
  logic [31:0] wd  [2];
  logic        rdy [2];
  logic        err [2];
  logic [31:0] rd  [2];
  logic [15:0] rc  [2];
  logic [15:0] wc  [2];

  int checks = 0;
  int fails  = 0;

`ifdef CACHE_MEM_RESPONDER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  always #5 clk = ~clk;

  cache_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(4096), .LATENCY(4)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(v[0]), .mem_ready_o(rdy[0]), .mem_we_i(we[0]),
    .mem_adr_i(adr[0]), .mem_wdata_i(wd[0]), .mem_rdata_o(rd[0]), .err_o(err[0]),
    .rd_cnt_o(rc[0]), .wr_cnt_o(wc[0]));

  cache_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(4096), .LATENCY(0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(v[1]), .mem_ready_o(rdy[1]), .mem_we_i(we[1]),
    .mem_adr_i(adr[1]), .mem_wdata_i(wd[1]), .mem_rdata_o(rd[1]), .err_o(err[1]),
    .rd_cnt_o(rc[1]), .wr_cnt_o(wc[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its ready pulse; lat=0 means it never came.
  task automatic req(input int u, input logic w, input logic [15:0] a, input logic [31:0] d,
                     input bit hold, output int lat, output logic [31:0] rdat, output logic e);
    v[u] = 1'b1; we[u] = w; adr[u] = a; wd[u] = d;
    lat = 0; rdat = '0; e = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (rdy[u]) begin
        lat = n; rdat = rd[u]; e = err[u];
        break;
      end
    end
    if (!hold) v[u] = 1'b0;
  endtask

  task automatic chk_idle(input int u, input string name);
    @(posedge clk); #1;
    chk({name, "_ready_low"}, 32'(rdy[u]), 32'd0);
    chk({name, "_err_low"}, 32'(err[u]), 32'd0);
  endtask

  task automatic chk_zero(input int u, input string name);
    chk({name, "_ready"}, 32'(rdy[u]), 32'd0);
    chk({name, "_err"}, 32'(err[u]), 32'd0);
    chk({name, "_rdata"}, rd[u], 32'd0);
    chk({name, "_rdcnt"}, 32'(rc[u]), 32'd0);
    chk({name, "_wrcnt"}, 32'(wc[u]), 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        tbl [8];
  int          lat;
  logic [31:0] r;
  logic        e;

  initial begin
    // rdata during a write's response is the previous response value held.
    tbl[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1] = '{1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 16'h0000, 32'h12345678, 32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b1, 16'h1000, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b1};
    tbl[4] = '{1'b0, 16'h1000, 32'h0,        32'h00000000, 1'b1};
    tbl[5] = '{1'b0, 16'h0000, 32'h0,        32'h12345678, 1'b0};
    tbl[6] = '{1'b0, 16'hFFFF, 32'h0,        32'h00000000, 1'b1};
    tbl[7] = '{1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0};

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      v[u] = 1'b0; we[u] = 1'b0; adr[u] = '0; wd[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero(0, "post_rst0");

    // LATENCY=4 table: response in cycle LATENCY+2 after acceptance.
    for (int i = 0; i < 8; i++) begin
      req(0, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, lat, r, e);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd6);
      chk($sformatf("vec%0d_rdata", i), r, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
      chk_idle(0, $sformatf("vec%0d", i));
    end
    chk("cnt0_rd", 32'(rc[0]), (STATS != 0) ? 32'd5 : 32'd0);
    chk("cnt0_wr", 32'(wc[0]), (STATS != 0) ? 32'd3 : 32'd0);

    // LATENCY=0: prime words 1..3, then back-to-back reads with valid held high.
    for (int i = 1; i <= 3; i++) begin
      req(1, 1'b1, 16'(i), 32'(i * 32'h11), 1'b0, lat, r, e);
      chk($sformatf("l0_wr%0d_lat", i), 32'(lat), 32'd2);
      chk_idle(1, $sformatf("l0_wr%0d", i));
    end
    req(1, 1'b0, 16'd1, 32'h0, 1'b1, lat, r, e);
    chk("b2b_rd1_lat", 32'(lat), 32'd2);
    chk("b2b_rd1_data", r, 32'h11);
    req(1, 1'b0, 16'd2, 32'h0, 1'b1, lat, r, e);
    chk("b2b_rd2_lat", 32'(lat), 32'd3);
    chk("b2b_rd2_data", r, 32'h22);
    req(1, 1'b0, 16'd3, 32'h0, 1'b0, lat, r, e);
    chk("b2b_rd3_lat", 32'(lat), 32'd3);
    chk("b2b_rd3_data", r, 32'h33);
    chk("b2b_rd3_err", 32'(e), 32'd0);
    chk_idle(1, "b2b_end");
    chk("cnt1_rd", 32'(rc[1]), (STATS != 0) ? 32'd3 : 32'd0);
    chk("cnt1_wr", 32'(wc[1]), (STATS != 0) ? 32'd3 : 32'd0);

`ifdef CACHE_MEM_RESPONDER_STATS_EN
    force u_dut0.rd_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release u_dut0.rd_cnt_q;
    req(0, 1'b0, 16'h0010, 32'h0, 1'b0, lat, r, e);
    chk("sat_rd_lat", 32'(lat), 32'd6);
    chk_idle(0, "sat");
    chk("sat_rd_cnt", 32'(rc[0]), 32'h0000FFFF);
    chk("sat_wr_cnt", 32'(wc[0]), 32'd3);
`endif

    // Reset in cycle 2 of a read: no response, outputs zero, RAM retained.
    v[0] = 1'b1; we[0] = 1'b0; adr[0] = 16'h0010;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    v[0]  = 1'b0;
    #1;
    chk_zero(0, "midrst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst_hold%0d", i), 32'(rdy[0]), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("after_rst%0d_ready", i), 32'(rdy[0]), 32'd0);
      chk($sformatf("after_rst%0d_rdata", i), rd[0], 32'd0);
    end
    chk_zero(0, "after_rst");
    req(0, 1'b0, 16'h0010, 32'h0, 1'b0, lat, r, e);
    chk("fresh_lat", 32'(lat), 32'd6);
    chk("fresh_data", r, 32'hDEADBEEF);
    chk("fresh_err", 32'(e), 32'd0);
    chk_idle(0, "fresh");
    chk("fresh_rdcnt", 32'(rc[0]), (STATS != 0) ? 32'd1 : 32'd0);
    req(1, 1'b0, 16'd2, 32'h0, 1'b0, lat, r, e);
    chk("l0_keep_lat", 32'(lat), 32'd2);
    chk("l0_keep_data", r, 32'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
